// File: rtl/dsm_coef_mac_sched.sv
// dsm_coef_mac_sched
//   One serial shift-add constant-coefficient multiplier shared round-robin
//   among NCH delta-sigma stages. Each channel owns a shift mask: bit s set
//   adds (x >>> s) to the product, one mask bit per cycle.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_i          per-channel level request, held with din_i until gnt_o
//   din_i          operands, channel k at din_i[k*W +: W]
//   gnt_o          one-hot 1-cycle pulse: operand captured
//   dout_o         product (two's complement, wraps modulo 2^W)
//   dout_vld_o     1-cycle pulse: dout_o / dout_id_o valid
//   dout_id_o      channel that dout_o belongs to
//   busy_o         high while multiplying
//   cfg_we_i       mask write strobe
//   cfg_addr_i     channel to configure (>= NCH ignored)
//   cfg_mask_i     new shift mask
//   cfg_neg_i      coefficient sign (only when COEF_NEG_EN is defined)
//
// Build option
//   COEF_NEG_EN    adds a per-channel sign bit; sign=1 negates the product.
module dsm_coef_mac_sched #(
    parameter int unsigned      W        = 41,
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      IDW      = 2,
    parameter int unsigned      MAXSH    = 12,
    parameter logic [MAXSH-1:0] DEF_MASK = 12'hDB0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req_i,
    input  logic [NCH*W-1:0]   din_i,
    output logic [NCH-1:0]     gnt_o,
    output logic [W-1:0]       dout_o,
    output logic               dout_vld_o,
    output logic [IDW-1:0]     dout_id_o,
    output logic               busy_o,
    input  logic               cfg_we_i,
    input  logic [IDW-1:0]     cfg_addr_i,
    input  logic [MAXSH-1:0]   cfg_mask_i
`ifdef COEF_NEG_EN
    ,
    input  logic               cfg_neg_i
`endif
);

    localparam int unsigned SHW = (MAXSH > 1) ? $clog2(MAXSH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic signed [W-1:0]     x_q, x_d;
    logic [MAXSH-1:0]        m_q, m_d;
    logic [IDW-1:0]          id_q, id_d;
    logic signed [W-1:0]     acc_q, acc_d;
    logic [SHW-1:0]          sh_q, sh_d;
    logic [NCH-1:0]          gnt_q, gnt_d;
    logic [W-1:0]            dout_q, dout_d;
    logic                    dout_vld_q, dout_vld_d;
    logic [IDW-1:0]          dout_id_q, dout_id_d;
    logic                    busy_q, busy_d;
    logic [MAXSH-1:0]        mask_q [NCH];
    logic [MAXSH-1:0]        mask_d [NCH];
`ifdef COEF_NEG_EN
    logic                    sgn_cfg_q [NCH];
    logic                    sgn_cfg_d [NCH];
    logic                    neg_q, neg_d;
`endif

    logic                    hit;
    logic [IDW-1:0]          sel;
    logic [W-1:0]            sel_din;
    logic [MAXSH-1:0]        sel_mask;
`ifdef COEF_NEG_EN
    logic                    sel_neg;
`endif
    logic signed [W-1:0]     shx;
    logic signed [W-1:0]     term;
    logic signed [W-1:0]     sum;

    // Round-robin search starting one past the last served channel.
    always_comb begin
        logic [IDW-1:0] cand;
        hit  = 1'b0;
        sel  = '0;
        cand = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NCH);
            if (!hit && req_i[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    // Operand, mask and sign of the selected channel (mask before any same-cycle write).
    always_comb begin
        sel_din  = '0;
        sel_mask = '0;
`ifdef COEF_NEG_EN
        sel_neg  = 1'b0;
`endif
        for (int unsigned k = 0; k < NCH; k++) begin
            if (sel == IDW'(k)) begin
                sel_din  = din_i[k*W +: W];
                sel_mask = mask_q[k];
`ifdef COEF_NEG_EN
                sel_neg  = sgn_cfg_q[k];
`endif
            end
        end
    end

    // Current partial term: arithmetic shift floors toward -inf.
    always_comb begin
        shx  = x_q >>> sh_q;
        term = m_q[sh_q] ? shx : '0;
        sum  = acc_q + term;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        x_d        = x_q;
        m_d        = m_q;
        id_d       = id_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        gnt_d      = '0;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        dout_id_d  = dout_id_q;
        mask_d     = mask_q;
`ifdef COEF_NEG_EN
        sgn_cfg_d  = sgn_cfg_q;
        neg_d      = neg_q;
`endif

        for (int unsigned k = 0; k < NCH; k++) begin
            if (cfg_we_i && (cfg_addr_i == IDW'(k))) begin
                mask_d[k] = cfg_mask_i;
`ifdef COEF_NEG_EN
                sgn_cfg_d[k] = cfg_neg_i;
`endif
            end
        end

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    x_d        = sel_din;
                    m_d        = sel_mask;
                    id_d       = sel;
                    acc_d      = '0;
                    sh_d       = '0;
                    rr_ptr_d   = sel;
                    gnt_d[sel] = 1'b1;
`ifdef COEF_NEG_EN
                    neg_d      = sel_neg;
`endif
                    state_d    = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = sum;
                sh_d  = sh_q + SHW'(1);
                if (sh_q == SHW'(MAXSH - 1)) begin
`ifdef COEF_NEG_EN
                    dout_d = neg_q ? -sum : sum;
`else
                    dout_d = sum;
`endif
                    dout_id_d  = id_q;
                    dout_vld_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_MAC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IDW'(NCH - 1);
            x_q        <= '0;
            m_q        <= '0;
            id_q       <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            gnt_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_id_q  <= '0;
            busy_q     <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                mask_q[k] <= DEF_MASK;
`ifdef COEF_NEG_EN
                sgn_cfg_q[k] <= 1'b0;
`endif
            end
`ifdef COEF_NEG_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            x_q        <= x_d;
            m_q        <= m_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            gnt_q      <= gnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_id_q  <= dout_id_d;
            busy_q     <= busy_d;
            mask_q     <= mask_d;
`ifdef COEF_NEG_EN
            sgn_cfg_q  <= sgn_cfg_d;
            neg_q      <= neg_d;
`endif
        end
    end

    assign gnt_o      = gnt_q;
    assign dout_o     = dout_q;
    assign dout_vld_o = dout_vld_q;
    assign dout_id_o  = dout_id_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_dsm_coef_mac_sched.sv
// Self-checking bench for dsm_coef_mac_sched: transaction-level model plus
// directed vectors with hand-computed results.
module tb_dsm_coef_mac_sched;

    localparam int W     = 41;
    localparam int NCH   = 4;
    localparam int IDW   = 2;
    localparam int MAXSH = 12;
    localparam logic [MAXSH-1:0] DEFM = 12'hDB0;

    localparam longint P20 = 64'sd1048576;
    localparam longint N40 = -64'sd1099511627776;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NCH-1:0]     req;
    logic [NCH*W-1:0]   din;
    logic [NCH-1:0]     gnt_o;
    logic [W-1:0]       dout_o;
    logic               dout_vld_o;
    logic [IDW-1:0]     dout_id_o;
    logic               busy_o;
    logic               cfg_we;
    logic [IDW-1:0]     cfg_addr;
    logic [MAXSH-1:0]   cfg_mask;
    logic               cfg_neg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dsm_coef_mac_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .din_i      (din),
        .gnt_o      (gnt_o),
        .dout_o     (dout_o),
        .dout_vld_o (dout_vld_o),
        .dout_id_o  (dout_id_o),
        .busy_o     (busy_o),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_mask_i (cfg_mask)
`ifdef COEF_NEG_EN
        ,
        .cfg_neg_i  (cfg_neg)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Product from the coefficient definition: sum of floor(x / 2^s) over set mask bits.
    function automatic logic [W-1:0] product(input logic [W-1:0] x,
                                             input logic [MAXSH-1:0] m, input bit neg);
        longint xv, acc;
        xv  = longint'($signed(x));
        acc = 0;
        for (int s = 0; s < MAXSH; s++)
            if (m[s]) acc += (xv >>> s);
        if (neg) acc = -acc;
        return W'(acc);
    endfunction

    // ---------------- model ----------------
    logic [MAXSH-1:0] mdl_mask [NCH];
    bit               mdl_neg  [NCH];
    int               mdl_left, mdl_rr, mdl_ch;
    logic [W-1:0]     mdl_res;
    logic [NCH-1:0]   exp_gnt;
    bit               exp_vld, exp_busy;
    logic [W-1:0]     exp_dout;
    int               exp_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                mdl_mask[k] = DEFM;
                mdl_neg[k]  = 1'b0;
            end
            mdl_left = 0;
            mdl_rr   = NCH - 1;
            mdl_ch   = 0;
            mdl_res  = '0;
            exp_gnt  = '0;
            exp_vld  = 1'b0;
            exp_busy = 1'b0;
            exp_dout = '0;
            exp_id   = 0;
        end else begin
            exp_gnt = '0;
            exp_vld = 1'b0;
            if (mdl_left > 0) begin
                mdl_left--;
                if (mdl_left == 0) begin
                    exp_vld  = 1'b1;
                    exp_dout = mdl_res;
                    exp_id   = mdl_ch;
                end
            end else begin
                for (int i = 1; i <= NCH; i++) begin
                    int k;
                    k = (mdl_rr + i) % NCH;
                    if (req[k]) begin
                        mdl_res    = product(din[k*W +: W], mdl_mask[k], mdl_neg[k]);
                        mdl_ch     = k;
                        mdl_rr     = k;
                        exp_gnt[k] = 1'b1;
                        mdl_left   = MAXSH;
                        break;
                    end
                end
            end
            exp_busy = (mdl_left > 0);
            if (cfg_we && int'(cfg_addr) < NCH) begin
                mdl_mask[cfg_addr] = cfg_mask;
`ifdef COEF_NEG_EN
                mdl_neg[cfg_addr]  = cfg_neg;
`endif
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            cmp("rst_gnt", gnt_o, 0);
            cmp("rst_vld", dout_vld_o, 0);
            cmp("rst_busy", busy_o, 0);
            cmp("rst_dout", dout_o, 0);
            cmp("rst_id", dout_id_o, 0);
        end else begin
            cmp("gnt", gnt_o, exp_gnt);
            cmp("vld", dout_vld_o, exp_vld);
            cmp("busy", busy_o, exp_busy);
            if (exp_vld) begin
                cmp("dout", $signed(dout_o), $signed(exp_dout));
                cmp("dout_id", dout_id_o, exp_id);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_din(input int k, input longint v);
        din[k*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string nm, output logic [NCH-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt_o != '0) begin
                g = gnt_o;
                t = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no gnt within 60 cycles", nm);
    endtask

    task automatic wait_vld(input string nm, output longint v, output int id, output int t);
        v  = 0;
        id = -1;
        t  = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dout_vld_o) begin
                v  = longint'($signed(dout_o));
                id = int'(dout_id_o);
                t  = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no dout_vld within 60 cycles", nm);
    endtask

    // Single-channel operation with literal result checks.
    task automatic op(input string nm, input int ch, input longint x,
                      input longint expv, output int lat);
        logic [NCH-1:0] g;
        int tg, tv, id;
        longint v;
        set_din(ch, x);
        req[ch] = 1'b1;
        wait_gnt(nm, g, tg);
        req = '0;
        cmp({nm, "_gnt"}, g, 1 << ch);
        wait_vld(nm, v, id, tv);
        cmp({nm, "_val"}, v, expv);
        cmp({nm, "_id"}, id, ch);
        lat = tv - tg;
    endtask

    function automatic int oh_idx(input logic [NCH-1:0] g);
        oh_idx = -1;
        for (int k = 0; k < NCH; k++) if (g[k]) oh_idx = k;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [NCH-1:0] g;
        int     tg, tv, id, lat;
        longint v;
        int     ord [5];
        int     tgs [5];

        req = '0; din = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_neg = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Positive operand, default mask; capture-to-valid latency.
        op("t1", 0, P20, 112128, lat);
        cmp("t1_lat", lat, 12);

        // Negative operand: sign extension and floor truncation.
        op("t2", 0, -2048, -219, lat);

        // All channels requesting from reset: order 0,1,2,3,0, 13 cycles apart.
        do_reset();
        set_din(0, P20);
        set_din(1, -2048);
        set_din(2, 12345);
        set_din(3, -777777);
        req = '1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("t3", g, tg);
            ord[i] = oh_idx(g);
            tgs[i] = tg;
        end
        req = '0;
        wait_vld("t3_last", v, id, tv);
        cmp("t3_last_val", v, 112128);
        cmp("t3_last_id", id, 0);
        cmp("t3_ord0", ord[0], 0);
        cmp("t3_ord1", ord[1], 1);
        cmp("t3_ord2", ord[2], 2);
        cmp("t3_ord3", ord[3], 3);
        cmp("t3_ord4", ord[4], 0);
        for (int i = 1; i < 5; i++) cmp("t3_gap", tgs[i] - tgs[i-1], 13);

        // Mask write during MAC affects only the next op on that channel.
        set_din(2, -2048);
        req[2] = 1'b1;
        wait_gnt("t4", g, tg);
        req = '0;
        cmp("t4_gnt", g, 4'b0100);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_mask = 12'h001;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_vld("t4", v, id, tv);
        cmp("t4_val", v, -219);
        cmp("t4_id", id, 2);
        op("t4b", 2, -5, -5, lat);

        // Mask write in the capture cycle: old mask used; then mask=0 gives 0.
        set_din(1, P20);
        req[1] = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mask = 12'h000;
        wait_gnt("tc", g, tg);
        cfg_we = 1'b0;
        req = '0;
        cmp("tc_gnt", g, 4'b0010);
        wait_vld("tc", v, id, tv);
        cmp("tc_val", v, 112128);
        op("tz", 1, P20, 0, lat);
        cmp("tz_lat", lat, 12);

        // Reset in the middle of an operation.
        set_din(0, P20);
        req[0] = 1'b1;
        wait_gnt("t5", g, tg);
        req = '0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        set_din(3, P20);
        req = 4'b1000;
        @(negedge clk);
        cmp("t5_rst_vld", dout_vld_o, 0);
        cmp("t5_rst_dout", dout_o, 0);
        cmp("t5_rst_busy", busy_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_gnt("t5b", g, tg);
        req = '0;
        cmp("t5b_gnt", g, 4'b1000);
        wait_vld("t5b", v, id, tv);
        cmp("t5b_val", v, 112128);
        cmp("t5b_id", id, 3);

`ifdef COEF_NEG_EN
        // Negative coefficient sign, including wrap of -(-2^40).
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mask = DEFM; cfg_neg = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        op("t6a", 1, P20, -112128, lat);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mask = 12'h001; cfg_neg = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        op("t6b", 1, N40, N40, lat);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
